// File: rtl/audio_mixer_n.sv
// N-channel time-multiplexed audio mixer feeding a first-order sigma-delta DAC; one channel per clock, a frame is NCH+2 cycles.
// The register port is always ready and has no backpressure. A sample reaches mix within 2*(NCH+2) cycles.
module audio_mixer_n #(
  parameter int          NCH        = 4,
  parameter int          W          = 8,
  parameter logic [7:0]  ZXREG_BASE = 8'h40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH*W-1:0] ch_in,
  input  logic             spk,
  input  logic             ear,
  input  logic             mic,
  input  logic [7:0]       addr,
  input  logic             iow,
  input  logic             ior,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             oe_n,
  output logic             audio_out
);

  localparam int MW = W + 1;
  localparam int SW = MW + 4;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_ACC, S_LATCH} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [MW-1:0] mix_q, mix_d;
  logic [MW:0]   acc_q, acc_d;
  logic [3:0]    vol_q [NCH];
  logic [3:0]    vol_d [NCH];
  logic [3:0]    ctrl_q, ctrl_d;

  logic [7:0]    offset;
  logic          hit;
  logic [3:0]    rd_val;
  logic [W-1:0]  ch_sel;
  logic [3:0]    vol_sel;
  logic [W+3:0]  prod;
  logic [W-1:0]  beep;
  logic          unused_bits;

  // Register decode: offsets 0..NCH-1 are volumes, NCH is ctrl; wraparound puts BASE-1 out of range.
  always_comb begin
    offset = addr - ZXREG_BASE;
    hit    = (offset <= 8'(NCH));
    rd_val = ctrl_q;
    for (int i = 0; i < NCH; i++) begin
      if (offset == 8'(i)) rd_val = vol_q[i];
    end
    oe_n = 1'b1;
    dout = 8'h00;
    if (ior && hit) begin
      oe_n = 1'b0;
      dout = {4'b0000, rd_val};
    end
  end

  always_comb begin
    ch_sel  = '0;
    vol_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IW'(i)) begin
        ch_sel  = ch_in[i*W +: W];
        vol_sel = vol_q[i];
      end
    end
    prod = {4'b0000, ch_sel} * {{W{1'b0}}, vol_sel};
    // Beeper weights land on distinct bits, so OR-ing them equals their sum.
    beep = '0;
    if (spk && ctrl_q[1]) beep[W-1] = 1'b1;
    if (ear && ctrl_q[2]) beep[W-3] = 1'b1;
    if (mic && ctrl_q[3]) beep[W-4] = 1'b1;
  end

  assign unused_bits = ^{din[7:4], prod[3:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    mix_d   = mix_q;
    ctrl_d  = ctrl_q;
    for (int i = 0; i < NCH; i++) begin
      vol_d[i] = vol_q[i];
      if (iow && offset == 8'(i)) vol_d[i] = din[3:0];
    end
    if (iow && offset == 8'(NCH)) ctrl_d = din[3:0];

    unique case (state_q)
      S_CLEAR: begin
        sum_d   = {{(SW-W){1'b0}}, beep};
        idx_d   = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        sum_d = sum_q + {{(SW-W){1'b0}}, prod[W+3:4]};
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NCH-1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (ctrl_q[0])                         mix_d = '0;
        else if (sum_q > SW'((1 << MW) - 1))   mix_d = '1;
        else                                   mix_d = sum_q[MW-1:0];
        state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase

    acc_d = {1'b0, acc_q[MW-1:0]} + {1'b0, mix_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      sum_q   <= '0;
      mix_q   <= '0;
      acc_q   <= '0;
      ctrl_q  <= 4'hE;
      for (int i = 0; i < NCH; i++) vol_q[i] <= 4'hF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
      ctrl_q  <= ctrl_d;
      for (int i = 0; i < NCH; i++) vol_q[i] <= vol_d[i];
    end
  end

  assign audio_out = acc_q[MW];

endmodule

// File: tb/tb_audio_mixer_n.sv
// Directed bench for audio_mixer_n (NCH=4, W=8): register port, mix values and bitstream density.
module tb_audio_mixer_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch_in;
  logic        spk, ear, mic;
  logic [7:0]  addr, din, dout;
  logic        iow, ior, oe_n, audio_out;

  int checks = 0;
  int errors = 0;
  int ones;

  audio_mixer_n #(.NCH(4), .W(8), .ZXREG_BASE(8'h40)) dut (
    .clk(clk), .reset(reset), .ch_in(ch_in), .spk(spk), .ear(ear), .mic(mic),
    .addr(addr), .iow(iow), .ior(ior), .din(din), .dout(dout), .oe_n(oe_n),
    .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; iow = 1'b1;
    tick(1);
    iow = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input int exp_dout, input int exp_oe_n);
    addr = a; ior = 1'b1;
    #1;
    chk({tag, "_dout"}, int'(dout), exp_dout);
    chk({tag, "_oe_n"}, int'(oe_n), exp_oe_n);
    ior = 1'b0;
  endtask

  task automatic count_ones(output int c);
    c = 0;
    repeat (512) begin
      @(negedge clk);
      if (audio_out) c++;
    end
  endtask

  initial begin
    reset = 1'b1; ch_in = '0; spk = 0; ear = 0; mic = 0;
    addr = 8'h00; din = 8'h00; iow = 0; ior = 0;
    tick(3);
    chk("rst_audio", int'(audio_out), 0);
    chk("rst_mix", int'(dut.mix_q), 0);
    #1;
    chk("idle_oe_n", int'(oe_n), 1);
    chk("idle_dout", int'(dout), 0);
    reset = 1'b0;
    tick(3);

    // Single channel: (255*15)>>4 = 239
    ch_in = {8'd0, 8'd0, 8'd0, 8'd255};
    tick(14);
    chk("single_mix", int'(dut.mix_q), 239);
    count_ones(ones);
    chk_range("single_density", ones, 238, 240);

    // Saturation: 4*239 + 128 = 1084 clamps to 511
    ch_in = {4{8'd255}}; spk = 1;
    tick(14);
    chk("sat_mix", int'(dut.mix_q), 511);
    count_ones(ones);
    chk_range("sat_density", ones, 510, 512);

    // Reset in the middle of a frame, with mix non-zero and a volume modified
    wr(8'h43, 8'h05);
    rd_chk("vol3_pre", 8'h43, 8'h05, 0);
    ch_in = '0; spk = 0;
    tick(2);
    reset = 1'b1;
    #1;
    chk("midrst_mix", int'(dut.mix_q), 0);
    chk("midrst_audio", int'(audio_out), 0);
    tick(1);
    reset = 1'b0;
    ones = 0;
    repeat (12) begin
      @(negedge clk);
      if (audio_out) ones++;
    end
    chk("postrst_ones", ones, 0);
    rd_chk("rst_vol0", 8'h40, 8'h0F, 0);
    rd_chk("rst_vol3", 8'h43, 8'h0F, 0);
    rd_chk("rst_ctrl", 8'h44, 8'h0E, 0);

    // Beeper only: ear weight 1<<5 = 32
    ear = 1;
    tick(14);
    chk("ear_mix", int'(dut.mix_q), 32);
    count_ones(ones);
    chk_range("ear_density", ones, 31, 33);
    wr(8'h44, 8'h0A);
    rd_chk("ctrl_0a", 8'h44, 8'h0A, 0);
    tick(14);
    chk("ear_off_mix", int'(dut.mix_q), 0);
    count_ones(ones);
    chk("ear_off_density", ones, 0);

    // Mute written mid-frame
    wr(8'h44, 8'h0E);
    ear = 0;
    ch_in = {8'd0, 8'd0, 8'd0, 8'd255};
    tick(14);
    chk("premute_mix", int'(dut.mix_q), 239);
    tick(2);
    wr(8'h44, 8'h0F);
    tick(16);
    chk("mute_mix", int'(dut.mix_q), 0);
    count_ones(ones);
    chk("mute_density", ones, 0);

    // Decode: only din[3:0] stored; ch2 scaled by 7/16 -> (255*7)>>4 = 111
    wr(8'h44, 8'h0E);
    wr(8'h42, 8'hA7);
    rd_chk("vol2", 8'h42, 8'h07, 0);
    ch_in = {8'd0, 8'd255, 8'd0, 8'd0};
    tick(14);
    chk("vol2_mix", int'(dut.mix_q), 111);
    count_ones(ones);
    chk_range("vol2_density", ones, 110, 112);
    wr(8'h45, 8'h03);
    wr(8'h3F, 8'h03);
    rd_chk("oob_hi", 8'h45, 8'h00, 1);
    rd_chk("oob_lo", 8'h3F, 8'h00, 1);
    rd_chk("keep_vol0", 8'h40, 8'h0F, 0);
    rd_chk("keep_vol1", 8'h41, 8'h0F, 0);
    rd_chk("keep_vol2", 8'h42, 8'h07, 0);
    rd_chk("keep_vol3", 8'h43, 8'h0F, 0);
    rd_chk("keep_ctrl", 8'h44, 8'h0E, 0);
    addr = 8'h42;
    #1;
    chk("noread_oe_n", int'(oe_n), 1);
    chk("noread_dout", int'(dout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
